// File: rtl/stream_mux.sv
// Registered N-to-1 stream multiplexer with per-channel valid/ready handshake.
// Source channel comes from an explicit select or a wrap-around round-robin arbiter.
module stream_mux #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SELW     = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_mode,
    input  logic [SELW-1:0]           i_sel,
    input  logic [CHANNELS-1:0]       i_in_valid,
    output logic [CHANNELS-1:0]       o_in_ready,
    input  logic [WIDTH*CHANNELS-1:0] i_in_data,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [WIDTH-1:0]          o_out_data,
    output logic [SELW-1:0]           o_out_ch
);

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SELW-1:0]     r_out_ch;
    logic [SELW-1:0]     r_ptr;

    logic                w_load;
    logic                w_gnt_vld;
    logic [SELW-1:0]     w_gnt_idx;
    logic [CHANNELS-1:0] w_gnt_onehot;
    logic                w_xfer;
    logic [WIDTH-1:0]    w_mux_data;
    logic [SELW-1:0]     w_ptr_nxt;

    assign w_load = !r_out_valid || i_out_ready;
    assign w_xfer = w_load && w_gnt_vld;

    // Grant: select mode matches SEL; round-robin scans from the pointer downwards in
    // reverse so the lowest offset from PTR is the one left standing.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        if (!i_mode) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (SELW'(i) == i_sel && i_in_valid[i]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = SELW'(i);
                end
            end
        end else begin
            for (int unsigned k = CHANNELS; k > 0; k--) begin
                automatic int unsigned j = (32'(r_ptr) + k - 1) % CHANNELS;
                if (i_in_valid[j]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = SELW'(j);
                end
            end
        end
    end

    // One-hot grant, data mux and next pointer derived from the granted index.
    always_comb begin
        w_gnt_onehot = '0;
        w_mux_data   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (w_gnt_vld && SELW'(i) == w_gnt_idx) begin
                w_gnt_onehot[i] = 1'b1;
                w_mux_data      = i_in_data[WIDTH*i +: WIDTH];
            end
        end
        w_ptr_nxt = (32'(w_gnt_idx) == CHANNELS - 1) ? '0 : SELW'(32'(w_gnt_idx) + 1);
    end

    assign o_in_ready = w_load ? w_gnt_onehot : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_load) begin
                r_out_valid <= w_xfer;
                if (w_xfer) begin
                    r_out_data <= w_mux_data;
                    r_out_ch   <= w_gnt_idx;
                end
            end
            if (w_xfer && i_mode) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: a 4-channel instance and a 3-channel instance
// (the latter exercises an out-of-range select).
module tb_stream_mux;

    logic         clk;
    logic         rstn;

    logic         mode4, rdy4;
    logic [1:0]   sel4;
    logic [3:0]   v4, ready4;
    logic [127:0] d4;
    logic         ovalid4;
    logic [31:0]  odata4;
    logic [1:0]   och4;

    logic         mode3, rdy3;
    logic [1:0]   sel3;
    logic [2:0]   v3, ready3;
    logic [95:0]  d3;
    logic         ovalid3;
    logic [31:0]  odata3;
    logic [1:0]   och3;

    int total = 0;
    int bad   = 0;

    stream_mux #(.WIDTH(32), .CHANNELS(4), .SELW(2)) u_dut4 (
        .i_clk(clk), .i_rstn(rstn), .i_mode(mode4), .i_sel(sel4),
        .i_in_valid(v4), .o_in_ready(ready4), .i_in_data(d4),
        .o_out_valid(ovalid4), .i_out_ready(rdy4), .o_out_data(odata4), .o_out_ch(och4)
    );

    stream_mux #(.WIDTH(32), .CHANNELS(3), .SELW(2)) u_dut3 (
        .i_clk(clk), .i_rstn(rstn), .i_mode(mode3), .i_sel(sel3),
        .i_in_valid(v3), .o_in_ready(ready3), .i_in_data(d3),
        .o_out_valid(ovalid3), .i_out_ready(rdy3), .o_out_data(odata3), .o_out_ch(och3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out4(input string tag, input logic vld, input logic [31:0] dat, input logic [1:0] ch);
        chk({tag, "_valid"}, 32'(ovalid4), 32'(vld));
        chk({tag, "_data"},  odata4, dat);
        chk({tag, "_ch"},    32'(och4), 32'(ch));
    endtask

    initial begin
        logic [3:0] exp_rdy;
        rstn  = 1'b0;
        mode4 = 1'b1; sel4 = 2'd0; v4 = 4'b1111; rdy4 = 1'b0;
        d4    = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
        mode3 = 1'b0; sel3 = 2'd0; v3 = 3'b000; rdy3 = 1'b1;
        d3    = {32'h33330002, 32'h33330001, 32'h33330000};

        // Reset with all channels valid
        repeat (2) tick();
        chk_out4("rst", 1'b0, 32'h0, 2'd0);
        chk("rst3_valid", 32'(ovalid3), 32'h0);

        // Round-robin fairness, first grant is channel 0
        rstn = 1'b1; rdy4 = 1'b1;
        for (int e = 0; e < 6; e++) begin
            #1;
            exp_rdy = 4'b0001 << (e % 4);
            chk("rr_ready", 32'(ready4), 32'(exp_rdy));
            tick();
            chk_out4("rr_out", 1'b1, 32'hCAFE0000 + 32'(e % 4), 2'(e % 4));
        end

        // Load 0x11 from channel 0 in select mode (pointer stays at 2)
        mode4 = 1'b0; sel4 = 2'd0; v4 = 4'b0001; d4[31:0] = 32'h11;
        #1 chk("ld11_ready", 32'(ready4), 32'h1);
        tick();
        chk_out4("ld11", 1'b1, 32'h11, 2'd0);

        // Backpressure while inputs wander
        rdy4 = 1'b0;
        for (int h = 0; h < 3; h++) begin
            mode4 = h[0];
            sel4  = 2'(h);
            v4    = (h == 0) ? 4'b1111 : 4'b0110;
            d4[31:0] = 32'hCAFE0000;
            #1 chk("bp_ready", 32'(ready4), 32'h0);
            tick();
            chk_out4("bp_hold", 1'b1, 32'h11, 2'd0);
        end
        mode4 = 1'b1; v4 = 4'b1111; rdy4 = 1'b1;
        #1 chk("bp_release_ready", 32'(ready4), 32'b0100);
        tick();
        chk_out4("bp_refill", 1'b1, 32'hCAFE0002, 2'd2);

        // Select mode with valid on a non-selected channel
        mode4 = 1'b0; sel4 = 2'd2; v4 = 4'b0101;
        #1 chk("sel_ready", 32'(ready4), 32'b0100);
        tick();
        chk_out4("sel_out", 1'b1, 32'hCAFE0002, 2'd2);

        // Wrap-around from pointer 3 to sparse channel 1
        mode4 = 1'b1; v4 = 4'b0010;
        #1 chk("wrap_ready", 32'(ready4), 32'b0010);
        tick();
        chk_out4("wrap_out", 1'b1, 32'hCAFE0001, 2'd1);
        v4 = 4'b1111;
        #1 chk("wrap_ptr2_ready", 32'(ready4), 32'b0100);
        tick();
        chk_out4("wrap_ptr2_out", 1'b1, 32'hCAFE0002, 2'd2);

        // Drain with no grant: valid drops, data and channel hold
        v4 = 4'b0000;
        #1 chk("empty_ready", 32'(ready4), 32'h0);
        tick();
        chk_out4("empty_out", 1'b0, 32'hCAFE0002, 2'd2);

        // Three-channel instance: legal select, then out-of-range select
        mode3 = 1'b0; sel3 = 2'd1; v3 = 3'b111; rdy3 = 1'b1;
        #1 chk("c3_sel1_ready", 32'(ready3), 32'b010);
        tick();
        chk("c3_sel1_valid", 32'(ovalid3), 32'h1);
        chk("c3_sel1_data", odata3, 32'h33330001);
        chk("c3_sel1_ch", 32'(och3), 32'h1);
        sel3 = 2'd3;
        #1 chk("c3_sel3_ready", 32'(ready3), 32'h0);
        tick();
        chk("c3_sel3_valid", 32'(ovalid3), 32'h0);
        chk("c3_sel3_data", odata3, 32'h33330001);

        // Reset mid-handshake after moving the pointer
        mode4 = 1'b1; v4 = 4'b1111; rdy4 = 1'b1;
        #1 chk("pre_rst_ready", 32'(ready4), 32'b1000);
        tick();
        chk_out4("pre_rst_ch3", 1'b1, 32'hCAFE0003, 2'd3);
        tick();
        chk_out4("pre_rst_ch0", 1'b1, 32'hCAFE0000, 2'd0);
        rdy4 = 1'b0;
        #1 chk("held_ready", 32'(ready4), 32'h0);
        rstn = 1'b0;
        tick();
        chk_out4("midrst", 1'b0, 32'h0, 2'd0);
        rstn = 1'b1; rdy4 = 1'b1;
        #1 chk("post_rst_ready", 32'(ready4), 32'b0001);
        tick();
        chk_out4("post_rst_out", 1'b1, 32'hCAFE0000, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
